control_sequencer: RTL and testbench

Controller-sequencer for the SAP-1 datapath and consumer of the instruction register's opcode nibble.
- Runs a 6-state one-hot T-state ring counter.
- Decodes the 4-bit opcode into the 12-bit active-mixed control word that drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
- Implements fetch (T1-T3) and execute (T4-T6) for LDA, ADD, SUB, OUT and HLT.

---
 rtl/sap1_pkg.sv | 30 +++
 rtl/control_sequencer_ring_counter.sv | 18 +
 rtl/control_sequencer.sv | 54 +++++
 tb/tb_control_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 opcodes, control-word bit indices, fetch words and T-state encodings.
package sap1_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int CP     = 11;
    localparam int EP     = 10;
    localparam int LM_BAR = 9;
    localparam int CE_BAR = 8;
    localparam int LI_BAR = 7;
    localparam int EI_BAR = 6;
    localparam int LA_BAR = 5;
    localparam int EA     = 4;
    localparam int SU     = 3;
    localparam int EU     = 2;
    localparam int LB_BAR = 1;
    localparam int LO_BAR = 0;
    localparam logic [11:0] CW_IDLE = 12'h3E3;
    localparam logic [11:0] T1_CW   = 12'h5E3;
    localparam logic [11:0] T2_CW   = 12'hBE3;
    localparam logic [11:0] T3_CW   = 12'h263;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
endpackage

// File: rtl/control_sequencer_ring_counter.sv
// ring_counter: 6-bit one-hot T-state ring, falling-edge clocked; hold beats restart beats advance.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] t_state
);
    logic [5:0] ring_q, ring_d;
    assign ring_d  = hold ? ring_q : restart ? T1 : {ring_q[4:0], ring_q[5]};
    assign t_state = ring_q;
    always_ff @(negedge clk or posedge clr) begin
        if (clr) ring_q <= T1;
        else     ring_q <= ring_d;
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 T-state sequencer and opcode decoder with halt latch.
// Build option VAR_CYCLE_EN shortens OUT/NOP/illegal to four T-states and LDA to five.
module control_sequencer
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        hlt,
    output logic        illegal
);
    logic        halted_q, halted_d;
    logic        t4, t5, known, restart;
    logic [11:0] exec_cw;
    assign t4    = t_state == T4;
    assign t5    = t_state == T5;
    assign known = opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
    always_comb begin
        exec_cw = CW_IDLE;
        case (opcode)
            OP_LDA:  exec_cw = t4 ? 12'h1A3 : t5 ? 12'h2C3 : CW_IDLE;
            OP_ADD:  exec_cw = t4 ? 12'h1A3 : t5 ? 12'h2E1 : 12'h3C7;
            OP_SUB:  exec_cw = t4 ? 12'h1A3 : t5 ? 12'h2E1 : 12'h3CF;
            OP_OUT:  exec_cw = t4 ? 12'h3F2 : CW_IDLE;
            default: exec_cw = CW_IDLE;
        endcase
    end
    // Once halted, the frozen T4 must ignore whatever opcode the IR now shows.
    assign con = halted_q ? CW_IDLE :
                 t_state == T1 ? T1_CW :
                 t_state == T2 ? T2_CW :
                 t_state == T3 ? T3_CW : exec_cw;
    assign hlt      = halted_q | (t4 & opcode == OP_HLT);
    assign illegal  = ~halted_q & t4 & ~known;
    assign halted_d = hlt;
`ifdef VAR_CYCLE_EN
    assign restart = (t4 & (opcode == OP_OUT | ~known)) | (t5 & opcode == OP_LDA);
`else
    assign restart = 1'b0;
`endif
    always_ff @(negedge clk or posedge clr) begin
        if (clr) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end
    ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (hlt),
        .restart (restart),
        .t_state (t_state)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench comparing the sequencer against an instruction-level model.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        hlt, illegal;

    typedef struct packed {
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
        logic        i;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .clk     (clk),
        .clr     (clr),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .hlt     (hlt),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [11:0] exec_word(input logic [3:0] op, input int k);
        logic [11:0] w [3];
        case (op)
            4'h0:    w = '{12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    w = '{12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    w = '{12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    w = '{12'h3F2, 12'h3E3, 12'h3E3};
            default: w = '{12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return w[k];
    endfunction

    function automatic int exec_len(input logic [3:0] op);
`ifdef VAR_CYCLE_EN
        return (op == 4'h1 || op == 4'h2) ? 3 : (op == 4'h0) ? 2 : 1;
`else
        return 3;
`endif
    endfunction

    function automatic bit is_illegal(input logic [3:0] op);
        return !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hE || op == 4'hF);
    endfunction

    function automatic logic [5:0] onehot(input int k);
        return 6'(1 << k);
    endfunction

    task automatic push_fetch(input int n);
        logic [11:0] f [3];
        f = '{12'h5E3, 12'hBE3, 12'h263};
        for (int k = 0; k < n; k++) q.push_back('{onehot(k), f[k], 1'b0, 1'b0});
    endtask

    // Called at the start of T1 (just after a falling edge); returns at the start of the next T1.
    task automatic run_instr(input logic [3:0] op);
        int len;
        push_fetch(3);
        opcode = 4'($urandom_range(15));
        if (op == 4'hF) begin
            for (int k = 0; k < 11; k++) q.push_back('{onehot(3), 12'h3E3, 1'b1, 1'b0});
            @(negedge clk); #1 opcode = op;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 11; k++) begin
                @(negedge clk); #1 opcode = 4'($urandom_range(15));
            end
            do_reset();
        end else begin
            len = exec_len(op);
            for (int k = 0; k < len; k++)
                q.push_back('{onehot(3 + k), exec_word(op, k), 1'b0, 1'(is_illegal(op) && k == 0)});
            @(negedge clk); #1 opcode = op;
            repeat (2 + len) @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        chk("rst_t", 32'(t_state), 32'h01);
        chk("rst_con", 32'(con), 32'h5E3);
        chk("rst_hlt", 32'(hlt), 32'h0);
        chk("rst_ill", 32'(illegal), 32'h0);
        @(negedge clk); #1 clr = 1'b0;
        #1;
        chk("rel_t", 32'(t_state), 32'h01);
        chk("rel_con", 32'(con), 32'h5E3);
        chk("rel_hlt", 32'(hlt), 32'h0);
    endtask

    always @(posedge clk) begin
        if (!clr && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("t_state", 32'(t_state), 32'(e.t));
            chk("con", 32'(con), 32'(e.c));
            chk("hlt", 32'(hlt), 32'(e.h));
            chk("illegal", 32'(illegal), 32'(e.i));
        end
    end

    initial begin
        logic [3:0] dir [8];
        dir = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7, 4'h0, 4'hF, 4'h3};
        repeat (3) @(negedge clk);
        #1 clr = 1'b0;
        #1;
        chk("init_t", 32'(t_state), 32'h01);
        chk("init_con", 32'(con), 32'h5E3);
        for (int n = 0; n < 8; n++) run_instr(dir[n]);
        push_fetch(2);
        opcode = 4'h0;
        @(negedge clk);
        @(posedge clk); #2;
        do_reset();
        for (int n = 0; n < 40; n++) run_instr(4'($urandom_range(15)));
        repeat (2) @(posedge clk);
        #1 chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
